// File: rtl/systola_pkg.sv
// rtl/systola_pkg.sv - shared types and helpers for the systolic feeders
`ifndef SYSTOLA_LANE
`define SYSTOLA_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package systola_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - fixed-depth shift of {fire, data} for one array row
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_fire,
    input  logic [DW-1:0] in_data,
    output logic          fire,
    output logic [DW-1:0] data
);

    logic [DEPTH-1:0] fire_q;
    logic [DW-1:0]    data_q [DEPTH];

    // Shift fire and data together one stage per clock; reset flushes every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            fire_q[0] <= in_fire;
            data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                fire_q[i] <= fire_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign fire = fire_q[DEPTH-1];
    assign data = data_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// rtl/act_skew_feeder.sv - diagonal-skew feeder for one edge of the PE array
module act_skew_feeder
    import systola_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int DW   = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ROWS*DW-1:0] in_data,
    input  logic               in_last,
    output logic [ROWS-1:0]    fire,
    output logic [ROWS*DW-1:0] a,
    output logic               done
);

    localparam int CW = $clog2(ROWS) + 1;

    state_t        state;
    logic [CW-1:0] drain_cnt;
    logic          accept;

    assign accept = in_valid & in_ready;

    // Stream FSM: in_ready and done are registered from the next state so nothing
    // combinational reaches them from in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (in_last) begin
                            if (ROWS > 1) begin
                                state     <= DRAIN;
                                drain_cnt <= CW'(ROWS - 1);
                                in_ready  <= 1'b0;
                            end else begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    // Last vector reaches row ROWS-1 exactly when the count hits 1.
                    if (drain_cnt == CW'(1)) begin
                        state     <= IDLE;
                        drain_cnt <= '0;
                        done      <= 1'b1;
                        in_ready  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Row r gets r+1 register stages; a non-accept cycle injects a zero bubble.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW-1:0] lane_in;
        assign lane_in = accept ? `SYSTOLA_LANE(in_data, r, DW) : '0;

        skew_delay_line #(
            .DEPTH (r + 1),
            .DW    (DW)
        ) u_delay (
            .clk     (clk),
            .rst     (rst),
            .in_fire (accept),
            .in_data (lane_in),
            .fire    (fire[r]),
            .data    (`SYSTOLA_LANE(a, r, DW))
        );
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// tb/tb_act_skew_feeder.sv - self-checking bench for act_skew_feeder
module tb_act_skew_feeder;

    localparam int ROWS = 4;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [ROWS*DW-1:0] in_data;
    logic               in_last;
    logic [ROWS-1:0]    fire;
    logic [ROWS*DW-1:0] a;
    logic               done;

    always #5 clk = ~clk;

    act_skew_feeder #(.ROWS(ROWS), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .fire     (fire),
        .a        (a),
        .done     (done)
    );

    typedef struct packed {
        logic               f;
        logic [ROWS*DW-1:0] v;
    } slot_t;

    int    vectors     = 0;
    int    miscompares = 0;
    slot_t hist[$];          // hist[r] = what was injected r edges ago
    int    t;                // edges since reset
    int    last_k;           // edge of the most recent last-beat accept
    logic  exp_ready;
    logic  exp_done;
    logic  acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int r = 0; r < ROWS; r++) begin
            chk($sformatf("fire[%0d]", r), 64'(fire[r]), 64'(hist[r].f));
            chk($sformatf("a[%0d]", r), 64'(a[r*DW +: DW]), 64'(hist[r].v[r*DW +: DW]));
        end
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("done", 64'(done), 64'(exp_done));
    endtask

    task automatic model_reset();
        hist = {};
        repeat (ROWS) hist.push_back('0);
        t         = 0;
        last_k    = -1000;
        exp_ready = 1'b0;
        exp_done  = 1'b0;
    endtask

    // One clock: drive inputs, advance the reference model, sample 1 time unit after the edge.
    task automatic step(input logic v, input logic l, input logic [ROWS*DW-1:0] d);
        slot_t s;
        in_valid = v;
        in_last  = l;
        in_data  = d;
        @(posedge clk);
        t++;
        acc = v && exp_ready;
        s = '0;
        if (acc) begin
            s.f = 1'b1;
            s.v = d;
        end
        hist.push_front(s);
        void'(hist.pop_back());
        if (acc && l) last_k = t;
        exp_done  = (t == last_k + ROWS - 1);
        exp_ready = !(t >= last_k && t <= last_k + ROWS - 2);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step(1'b0, 1'b0, '0);
    endtask

    function automatic logic [ROWS*DW-1:0] ramp(input int n);
        return {8'(4 + n), 8'(3 + n), 8'(2 + n), 8'(1 + n)};
    endfunction

    task automatic four_vector_stream();
        for (int n = 0; n < 4; n++) step(1'b1, n == 3, ramp(n));
        // valid held with 0xFF data during drain; must never be accepted
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, {ROWS*DW{1'b1}});
            chk("drain_no_accept", 64'(acc), 64'd0);
        end
        chk("done_at_row3_last", 64'(done), 64'd1);
        chk("row3_final_value", 64'(a[3*DW +: DW]), 64'd7);
    endtask

    initial begin
        do_reset();
        chk("ready_after_release", 64'(in_ready), 64'd1);

        four_vector_stream();
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < ROWS; i++) step(1'b0, 1'b0, '0);

        // bubble: valid 1,0,1 then last
        step(1'b1, 1'b0, 32'hA1B2C3D4);
        step(1'b0, 1'b0, 32'hDEADBEEF);
        step(1'b1, 1'b1, 32'h05060708);
        for (int i = 0; i < ROWS; i++) step(1'b0, 1'b0, '0);

        // single-vector stream, then back-to-back stream in the cycle after done
        step(1'b1, 1'b1, 32'h11223344);
        chk("single_row0", 64'(a[7:0]), 64'h44);
        step(1'b0, 1'b0, '0);
        chk("single_row1", 64'(a[15:8]), 64'h33);
        step(1'b0, 1'b0, '0);
        chk("single_row2", 64'(a[23:16]), 64'h22);
        step(1'b0, 1'b0, '0);
        chk("single_row3", 64'(a[31:24]), 64'h11);
        chk("single_done", 64'(done), 64'd1);
        step(1'b1, 1'b0, 32'h01020304);
        chk("b2b_accept", 64'(acc), 64'd1);
        step(1'b1, 1'b0, 32'h0A0B0C0D);

        // async reset mid-stream with data in flight
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_fire_clear", 64'(fire), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        step(1'b0, 1'b0, '0);
        four_vector_stream();

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom);
            if (i == 150) do_reset();
        end
        for (int i = 0; i < ROWS + 1; i++) step(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
